// File: rtl/layer_1_activation_streamer.sv
// Captures the 20 layer-1 leaky-ReLU activations on load, requantizes them to
// SIZE-bit fixed point and streams them one per valid/ready beat to layer 2.
module layer_1_activation_streamer #(
    parameter int SIZE = 16,
    parameter int FRAC = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [2*SIZE-1:0]   in_1,
    input  logic [2*SIZE-1:0]   in_2,
    input  logic [2*SIZE-1:0]   in_3,
    input  logic [2*SIZE-1:0]   in_4,
    input  logic [2*SIZE-1:0]   in_5,
    input  logic [2*SIZE-1:0]   in_6,
    input  logic [2*SIZE-1:0]   in_7,
    input  logic [2*SIZE-1:0]   in_8,
    input  logic [2*SIZE-1:0]   in_9,
    input  logic [2*SIZE-1:0]   in_10,
    input  logic [2*SIZE-1:0]   in_11,
    input  logic [2*SIZE-1:0]   in_12,
    input  logic [2*SIZE-1:0]   in_13,
    input  logic [2*SIZE-1:0]   in_14,
    input  logic [2*SIZE-1:0]   in_15,
    input  logic [2*SIZE-1:0]   in_16,
    input  logic [2*SIZE-1:0]   in_17,
    input  logic [2*SIZE-1:0]   in_18,
    input  logic [2*SIZE-1:0]   in_19,
    input  logic [2*SIZE-1:0]   in_20,
    output logic [SIZE-1:0]     out_data,
    output logic [4:0]          out_index,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int          N_ACT    = 20;
    localparam logic [4:0]  LAST_IDX = 5'd19;

    localparam logic signed [2*SIZE-1:0] W_MAX = {{(SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
    localparam logic signed [2*SIZE-1:0] W_MIN = {{(SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_idx;
    logic [4:0]         w_idx_nxt;
    logic [SIZE-1:0]    r_buf [0:N_ACT-1];
    logic               r_done;
    logic               w_done_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic               w_capture;
    logic               w_accept;
    logic               w_final;
    logic [2*SIZE-1:0]  w_in [0:N_ACT-1];

    assign w_in[0]  = in_1;
    assign w_in[1]  = in_2;
    assign w_in[2]  = in_3;
    assign w_in[3]  = in_4;
    assign w_in[4]  = in_5;
    assign w_in[5]  = in_6;
    assign w_in[6]  = in_7;
    assign w_in[7]  = in_8;
    assign w_in[8]  = in_9;
    assign w_in[9]  = in_10;
    assign w_in[10] = in_11;
    assign w_in[11] = in_12;
    assign w_in[12] = in_13;
    assign w_in[13] = in_14;
    assign w_in[14] = in_15;
    assign w_in[15] = in_16;
    assign w_in[16] = in_17;
    assign w_in[17] = in_18;
    assign w_in[18] = in_19;
    assign w_in[19] = in_20;

    // Drop FRAC fractional bits (floor), then clamp into the signed SIZE-bit range.
    function automatic logic [SIZE-1:0] requant(input logic [2*SIZE-1:0] a);
        logic signed [2*SIZE-1:0] s;
        s = $signed(a) >>> FRAC;
        if (s > W_MAX) begin
            return W_MAX[SIZE-1:0];
        end else if (s < W_MIN) begin
            return W_MIN[SIZE-1:0];
        end else begin
            return s[SIZE-1:0];
        end
    endfunction

    assign w_accept = (r_state == S_STREAM) && out_ready;
    assign w_final  = w_accept && (r_idx == LAST_IDX);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_capture     = 1'b0;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = 5'd0;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_done_nxt = 1'b1;
                        w_idx_nxt  = 5'd0;
                        // A load landing on the final beat chains straight into the next stream.
                        if (load) begin
                            w_capture = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end
                if (load && !w_final) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 5'd0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < N_ACT; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_capture) begin
                for (int i = 0; i < N_ACT; i++) begin
                    r_buf[i] <= requant(w_in[i]);
                end
            end
        end
    end

    // All outputs decode registered state, so out_ready never reaches out_valid.
    assign out_valid = (r_state == S_STREAM);
    assign busy      = (r_state == S_STREAM);
    assign out_data  = r_buf[r_idx];
    assign out_index = r_idx;
    assign out_last  = (r_state == S_STREAM) && (r_idx == LAST_IDX);
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_layer_1_activation_streamer.sv
// Directed bench for layer_1_activation_streamer: stimulus pushes expected
// beats into a queue, a negedge monitor pops and compares accepted beats.
module tb_layer_1_activation_streamer;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        out_ready;
  logic [31:0] tb_in [N];
  logic [15:0] out_data;
  logic [4:0]  out_index;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        overrun;

  // Expected beat: {last, index[4:0], data[15:0]}
  logic [21:0] exp_q[$];
  logic [31:0] vin  [N];
  logic [15:0] vexp [N];
  logic        exp_done = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;
  logic [5:0]  ready_pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1

  layer_1_activation_streamer #(.SIZE(16), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .load(load),
    .in_1(tb_in[0]),   .in_2(tb_in[1]),   .in_3(tb_in[2]),   .in_4(tb_in[3]),
    .in_5(tb_in[4]),   .in_6(tb_in[5]),   .in_7(tb_in[6]),   .in_8(tb_in[7]),
    .in_9(tb_in[8]),   .in_10(tb_in[9]),  .in_11(tb_in[10]), .in_12(tb_in[11]),
    .in_13(tb_in[12]), .in_14(tb_in[13]), .in_15(tb_in[14]), .in_16(tb_in[15]),
    .in_17(tb_in[16]), .in_18(tb_in[17]), .in_19(tb_in[18]), .in_20(tb_in[19]),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .overrun(overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a beat with valid && ready at negedge is accepted at the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_done || done) check("done_pulse", {31'd0, done}, {31'd0, exp_done});
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {27'd0, out_index}, 32'hFFFF_FFFF);
        end else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          check("beat", {10'd0, out_last, out_index, out_data}, {10'd0, e});
          if (e[21]) exp_done = 1'b1;
        end
      end else if (out_valid && exp_q.size() != 0) begin
        check("stall_stable", {10'd0, out_last, out_index, out_data}, {10'd0, exp_q[0]});
      end
    end
  end

  // ---------------- vectors ----------------
  task automatic set_t2();
    for (int k = 1; k <= N; k++) begin
      vin[k-1]  = 32'(k) << 16;
      vexp[k-1] = 16'(k << 8);
    end
  endtask

  task automatic set_t3();
    vin[0] = 32'h7FFF_FFFF; vexp[0] = 16'h7FFF;
    vin[1] = 32'h8000_0000; vexp[1] = 16'h8000;
    vin[2] = 32'hFFFF_FF80; vexp[2] = 16'hFFFF;
    vin[3] = 32'h0000_00FF; vexp[3] = 16'h0000;
    for (int i = 4; i < N; i++) begin
      vin[i]  = 32'(-(i * 65536));
      vexp[i] = 16'(-(i * 256));
    end
  endtask

  task automatic set_t4();
    for (int k = 1; k <= N; k++) begin
      vin[k-1]  = 32'(-(k * 65536) - 1);
      vexp[k-1] = 16'(-(k * 256) - 1);
    end
  endtask

  task automatic set_t6b();
    for (int i = 0; i < N; i++) begin
      vin[i]  = 32'(i * 4096 + 255);
      vexp[i] = 16'(i * 16);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_inputs();
    for (int i = 0; i < N; i++) tb_in[i] = vin[i];
  endtask

  task automatic push_exp();
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), 5'(i), vexp[i]});
  endtask

  task automatic pulse_load(input bit chk_start);
    apply_inputs();
    push_exp();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    if (chk_start) begin
      check("start_valid", {31'd0, out_valid}, 32'd1);
      check("start_index", {27'd0, out_index}, 32'd0);
      check("start_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic run_stream(input int mode, output int cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      out_ready = (mode == 0) ? 1'b1 : ready_pat[c % 6];
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      check("stream_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    cycles = c;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    reset = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) tb_in[i] = '0;
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_index", {27'd0, out_index}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    do_reset();
    check_idle("post_rst");

    // T1: reset mid-stream at beat 7
    set_t2();
    pulse_load(1'b1);
    out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t1_pre_index", {27'd0, out_index}, 32'd7);
    reset = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    #1;
    check_idle("t1_rst");
    check("t1_rst_index", {27'd0, out_index}, 32'd0);
    check("t1_rst_last", {31'd0, out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_idle("t1_after");
    out_ready = 1'b0;

    // T2: plain stream, ready held high
    set_t2();
    pulse_load(1'b1);
    run_stream(0, cyc);
    check("t2_cycles", cyc, 32'd20);
    check("t2_done_now", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check_idle("t2_end");

    // T3: saturation and sign
    set_t3();
    pulse_load(1'b1);
    run_stream(0, cyc);
    repeat (2) @(posedge clk);
    #1;

    // T4: backpressure
    set_t4();
    pulse_load(1'b1);
    run_stream(1, cyc);
    check("t4_done_now", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check_idle("t4_end");

    // T6: load coincident with final accept
    set_t2();
    pulse_load(1'b1);
    out_ready = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    check("t6_pre_last", {31'd0, out_last}, 32'd1);
    set_t6b();
    pulse_load(1'b1);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_new_data", {16'd0, out_data}, 32'd0);
    run_stream(0, cyc);
    check("t6_cycles", cyc, 32'd20);
    @(posedge clk); #1;
    check_idle("t6_end");
    check("t6_overrun", {31'd0, overrun}, 32'd0);

    // T5: load during stream is dropped and sets sticky overrun
    set_t2();
    pulse_load(1'b1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    set_t3();
    apply_inputs();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("t5_overrun_set", {31'd0, overrun}, 32'd1);
    check("t5_index_kept", {27'd0, out_index}, 32'd6);
    run_stream(0, cyc);
    @(posedge clk); #1;
    check_idle("t5_end");
    check("t5_overrun_idle", {31'd0, overrun}, 32'd1);
    set_t4();
    pulse_load(1'b1);
    check("t5_overrun_next", {31'd0, overrun}, 32'd1);
    run_stream(1, cyc);
    repeat (2) @(posedge clk);
    #1;
    check("t5_overrun_after", {31'd0, overrun}, 32'd1);
    do_reset();
    check("t5_overrun_clr", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
